// File: rtl/rect_scan_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rect_scan_if : request/pixel bundle between draw control and rect_scan_gen
// Rev 1.0
// ----------------------------------------------------------------------------
interface rect_scan_if #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 15
);
  logic              start;
  logic              abort;
  logic              hold;
  logic [X_W-1:0]    xInit;
  logic [Y_W-1:0]    yInit;
  logic [X_W-1:0]    width;
  logic [Y_W-1:0]    height;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr;
  logic              plot;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, hold, xInit, yInit, width, height,
    input  x, y, addr, plot, busy, done
  );

  modport slave (
    input  start, abort, hold, xInit, yInit, width, height,
    output x, y, addr, plot, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/rect_scan_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rect_scan_gen : row-major rectangle raster scan with clipping, hold, abort
// Rev 1.0
// ----------------------------------------------------------------------------
module rect_scan_gen #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int ADDR_W   = 15
) (
  input  wire logic   clk,
  input  wire logic   reset,
  rect_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_W:0] C_SCREEN_W = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] C_SCREEN_H = SCREEN_H[Y_W:0];

  state_t            r_state;
  logic [X_W-1:0]    r_x_base;
  logic [X_W-1:0]    r_width;
  logic [Y_W-1:0]    r_height;
  logic [X_W-1:0]    r_col;
  logic [Y_W-1:0]    r_row;
  // One extra bit so origin+offset overflow lands off-screen instead of wrapping.
  logic [X_W:0]      r_x_ext;
  logic [Y_W:0]      r_y_ext;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;

  logic w_in_screen;
  logic w_last_col;
  logic w_last_row;

  assign w_in_screen = (r_x_ext < C_SCREEN_W) && (r_y_ext < C_SCREEN_H);
  assign w_last_col  = (r_col == r_width - X_W'(1));
  assign w_last_row  = (r_row == r_height - Y_W'(1));

  assign bus.plot = (r_state == SCAN) && !bus.hold && !bus.abort && w_in_screen;
  assign bus.x    = r_x_ext[X_W-1:0];
  assign bus.y    = r_y_ext[Y_W-1:0];
  assign bus.addr = r_addr;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_x_base <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_x_ext  <= '0;
      r_y_ext  <= '0;
      r_addr   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if ((bus.width != '0) && (bus.height != '0)) begin
              r_x_base <= bus.xInit;
              r_width  <= bus.width;
              r_height <= bus.height;
              r_col    <= '0;
              r_row    <= '0;
              r_addr   <= '0;
              r_x_ext  <= {1'b0, bus.xInit};
              r_y_ext  <= {1'b0, bus.yInit};
              r_state  <= SCAN;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        SCAN: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (!bus.hold) begin
            if (w_last_col && w_last_row) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              // addr steps on clipped pixels too, keeping sprite data aligned.
              r_addr <= r_addr + ADDR_W'(1);
              if (!w_last_col) begin
                r_col   <= r_col + X_W'(1);
                r_x_ext <= r_x_ext + (X_W+1)'(1);
              end else begin
                r_col   <= '0;
                r_x_ext <= {1'b0, r_x_base};
                r_row   <= r_row + Y_W'(1);
                r_y_ext <= r_y_ext + (Y_W+1)'(1);
              end
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rect_scan_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rect_scan_gen : directed + randomized scans checked against a pixel-list model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rect_scan_gen;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int ADDR_W = 15;
  localparam int SW = 160;
  localparam int SH = 120;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  rect_scan_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) bus ();

  rect_scan_gen #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SW), .SCREEN_H(SH), .ADDR_W(ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge while the DUT is idle.
  task automatic issue_start(input int x0, input int y0, input int w, input int h);
    bus.start  = 1'b1;
    bus.xInit  = X_W'(x0);
    bus.yInit  = Y_W'(y0);
    bus.width  = X_W'(w);
    bus.height = Y_W'(h);
    step();
    bus.start  = 1'b0;
  endtask

  task automatic chk_pixel(input string tag, input int x0, input int y0, input int w,
                           input int p, input logic exp_plot);
    int c, r;
    c = p % w;
    r = p / w;
    chk({tag, ".x"},    {24'd0, bus.x}, (x0 + c) % 256);
    chk({tag, ".y"},    {25'd0, bus.y}, (y0 + r) % 128);
    chk({tag, ".addr"}, {17'd0, bus.addr}, p);
    chk({tag, ".plot"}, {31'd0, bus.plot}, {31'd0, exp_plot});
    chk({tag, ".busy"}, {31'd0, bus.busy}, 1);
    chk({tag, ".done"}, {31'd0, bus.done}, 0);
  endtask

  // Model: the rectangle is the list of pixels p = r*w + c in row-major order;
  // a pixel is written only if its unwrapped coordinate lies on screen.
  task automatic run_scan(input string tag, input int x0, input int y0, input int w,
                          input int h, input int hold_idx, input int hold_len,
                          input bit rnd);
    int holds, nplot, exp_plots, last;
    bit vis;
    nplot = 0;
    exp_plots = 0;
    last = w * h - 1;
    issue_start(x0, y0, w, h);
    for (int p = 0; p <= last; p++) begin
      vis = ((x0 + p % w) < SW) && ((y0 + p / w) < SH);
      if (vis) exp_plots++;
      holds = (p == hold_idx) ? hold_len : 0;
      if (rnd && ($urandom_range(0, 3) == 0)) holds = $urandom_range(1, 2);
      for (int k = 0; k <= holds; k++) begin
        bus.hold = (k < holds);
        if (rnd) begin
          bus.start  = 1'($urandom_range(0, 1));
          bus.xInit  = X_W'($urandom);
          bus.width  = X_W'($urandom);
        end
        @(negedge clk);
        chk_pixel(tag, x0, y0, w, p, (k < holds) ? 1'b0 : vis);
        if (bus.plot === 1'b1) nplot++;
        step();
      end
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, bus.done}, 1);
    chk({tag, ".done_busy"},  {31'd0, bus.busy}, 1);
    chk({tag, ".done_plot"},  {31'd0, bus.plot}, 0);
    chk({tag, ".final_addr"}, {17'd0, bus.addr}, last);
    step();
    @(negedge clk);
    chk({tag, ".idle_done"}, {31'd0, bus.done}, 0);
    chk({tag, ".idle_busy"}, {31'd0, bus.busy}, 0);
    chk({tag, ".idle_x"},    {24'd0, bus.x}, (x0 + last % w) % 256);
    chk({tag, ".idle_y"},    {25'd0, bus.y}, (y0 + last / w) % 128);
    chk({tag, ".idle_addr"}, {17'd0, bus.addr}, last);
    chk({tag, ".nplots"}, nplot, exp_plots);
    step();
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
    bus.xInit = '0; bus.yInit = '0; bus.width = '0; bus.height = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst.x",    {24'd0, bus.x}, 0);
    chk("rst.y",    {25'd0, bus.y}, 0);
    chk("rst.addr", {17'd0, bus.addr}, 0);
    chk("rst.plot", {31'd0, bus.plot}, 0);
    chk("rst.busy", {31'd0, bus.busy}, 0);
    chk("rst.done", {31'd0, bus.done}, 0);
    step();
    reset = 1'b1;
    step();

    run_scan("basic", 10, 20, 3, 2, -1, 0, 1'b0);
    run_scan("full", 0, 0, 160, 120, -1, 0, 1'b0);
    run_scan("clip", 150, 110, 16, 16, -1, 0, 1'b0);
    run_scan("hold", 10, 20, 3, 2, 2, 4, 1'b0);
    run_scan("wrap", 250, 118, 12, 4, -1, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_scan("rand", $urandom_range(0, 255), $urandom_range(0, 127),
               $urandom_range(1, 20), $urandom_range(1, 6), -1, 0, 1'b1);

    // Abort on the 4th pixel, with an ignored restart attempt on the 2nd.
    issue_start(10, 20, 3, 2);
    for (int p = 0; p < 3; p++) begin
      if (p == 1) begin
        bus.start = 1'b1; bus.xInit = 8'd99; bus.width = 8'd7;
      end
      @(negedge clk);
      chk_pixel("abort", 10, 20, 3, p, 1'b1);
      step();
      bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    chk_pixel("abort_cyc", 10, 20, 3, 3, 1'b0);
    step();
    bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort.busy", {31'd0, bus.busy}, 0);
      chk("abort.done", {31'd0, bus.done}, 0);
      chk("abort.plot", {31'd0, bus.plot}, 0);
      chk("abort.addr", {17'd0, bus.addr}, 3);
      chk("abort.y",    {25'd0, bus.y}, 21);
      step();
    end

    // Reset in the middle of a scan.
    issue_start(5, 5, 4, 4);
    step();
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("mrst.x",    {24'd0, bus.x}, 0);
    chk("mrst.y",    {25'd0, bus.y}, 0);
    chk("mrst.addr", {17'd0, bus.addr}, 0);
    chk("mrst.plot", {31'd0, bus.plot}, 0);
    chk("mrst.busy", {31'd0, bus.busy}, 0);
    chk("mrst.done", {31'd0, bus.done}, 0);
    step();
    reset = 1'b1;
    step();

    // Zero-size rectangles go straight to the done pulse.
    for (int i = 0; i < 2; i++) begin
      if (i == 0) issue_start(7, 7, 0, 5);
      else        issue_start(7, 7, 5, 0);
      @(negedge clk);
      chk("zero.done", {31'd0, bus.done}, 1);
      chk("zero.busy", {31'd0, bus.busy}, 1);
      chk("zero.plot", {31'd0, bus.plot}, 0);
      step();
      @(negedge clk);
      chk("zero.idle_done", {31'd0, bus.done}, 0);
      chk("zero.idle_busy", {31'd0, bus.busy}, 0);
      chk("zero.idle_plot", {31'd0, bus.plot}, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/rect_scan_gen.md
Name: rect_scan_gen

Overview:
Parametrised raster scan generator for the VGA pixel path.
- On a start pulse it walks a rectangle of run-time width and height, anchored at a run-time origin. The scan runs row-major: x fastest, then y.
- For each pixel it emits the screen coordinate, a linear sprite-memory address and a plot strobe.
- It replaces the fixed 40x40 and whole-screen scan modes, and adds screen clipping, hold/backpressure, abort and a done pulse.
- It sits between the draw control FSM and the sprite ROM / VGA adapter.

Parameters:
X_W, 8, width of x coordinate and rectangle width.
Y_W, 7, width of y coordinate and rectangle height.
SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped.
SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped.
ADDR_W, 15, width of sprite address; must hold (2^X_W-1)*(2^Y_W-1).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  begin scan; sampled only in IDLE.
abort  in  1  terminate scan; no done pulse.
hold  in  1  stall; freezes counters and suppresses plot.
xInit  in  X_W  origin x, latched on accepted start.
yInit  in  Y_W  origin y, latched on accepted start.
width  in  X_W  rectangle width in pixels, latched on start.
height  in  Y_W  rectangle height in pixels, latched on start.
x  out  X_W  current pixel x (xBase+col, low X_W bits).
y  out  Y_W  current pixel y (yBase+row, low Y_W bits).
addr  out  ADDR_W  linear sprite address, row*width+col.
plot  out  1  write-enable for the current pixel.
busy  out  1  high in SCAN and DONE.
done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE. x, y, addr, col, row, latched bases and sizes all =0. plot=0, busy=0, done=0. Reset overrides every other input, including mid-scan.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start==1 with width!=0 and height!=0 latches xInit, yInit, width and height. It clears col, row and addr, and moves to SCAN on the next edge.
  - start==1 with width==0 or height==0 moves to DONE directly; no plot is ever issued.
  - start==0 stays in IDLE.
- SCAN:
  - x=xBase+col and y=yBase+row are registered values for the current pixel.
  - plot is combinational: plot = (state==SCAN) & !hold & !abort & inScreen.
  - inScreen: xBase+col < SCREEN_W and yBase+row < SCREEN_H. Compare in X_W+1 / Y_W+1 bits so origin+offset overflow is clipped, not wrapped.
  - Advance on every edge with hold==0:
    - col<width-1: col+1.
    - Otherwise col=0 and row+1.
    - addr+1 on every advance, including clipped pixels, so sprite data stays aligned.
  - Last pixel (col==width-1, row==height-1) advancing: next state DONE; x, y and addr hold their final values.
  - hold==1: all counters frozen, plot=0, no state change.
  - Without hold, exactly width*height SCAN cycles elapse.
  - abort==1 in SCAN: next state IDLE, no done pulse, plot=0 that cycle. abort is ignored in other states.
  - start in SCAN or DONE is ignored; no re-latch.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge N, first plot in cycle N+1. Final plot in cycle N+width*height+holds. done asserted in the following cycle.
- Outputs x, y and addr retain their last values in IDLE until the next accepted start.
- Arithmetic: col and row counters are X_W and Y_W bits. addr is computed incrementally, with no multiplier.

Test Plan:
1. Reset, then start with xInit=10, yInit=20, width=3, height=2 -> plot high for 6 consecutive cycles.
   - (x,y): (10,20), (11,20), (12,20), (10,21), (11,21), (12,21).
   - addr 0..5.
   - done high exactly one cycle after the last pixel, then busy=0.
2. Full screen: origin (0,0), width=160, height=120 -> 19200 plots. The last plot is at x=159, y=119, addr=19199; done follows.
3. Clipping: origin (150,110), width=16, height=16 -> 256 SCAN cycles but only 100 plots (x 150..159, y 110..119). addr reaches 255; no x wraps to 0..5.
4. hold: 3x2 scan with hold=1 for 4 cycles while on the 3rd pixel -> plot=0 during the hold and x/y/addr frozen at (12,20)/2. Scan resumes with 6 total plots; done is 4 cycles later than in test 1.
5. Abort, reset and ignored start:
   - abort on the 4th pixel of a 3x2 scan -> IDLE next cycle; done never asserts.
   - A new start mid-scan is ignored.
   - reset low mid-scan -> all outputs 0 after the edge.
6. Zero size: start with width=0, height=5 -> no plot, done pulses one cycle after start, then IDLE.
